// File: rtl/serial_pkg.sv
// Types and constants shared by the serial transmitter and receiver.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int CLKS_PER_BIT_DEFAULT = 167;
    localparam int FRAME_BITS           = 8;

endpackage

// File: rtl/serialrx_sync.sv
// Two-flop synchronizer for the serial line, reset to the idle (high) level.
// With SERIALRX_MAJORITY_EN it also keeps a 3-tap history and outputs the 2-of-3 vote.
module serialrx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic rx_s,
    output logic rx_vote
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            meta <= rx;
            rx_s <= meta;
        end
    end

`ifdef SERIALRX_MAJORITY_EN
    logic h1, h2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h1 <= 1'b1;
            h2 <= 1'b1;
        end else begin
            h1 <= rx_s;
            h2 <= h1;
        end
    end

    // Vote over the current and two previous synchronized samples.
    assign rx_vote = (rx_s & h1) | (rx_s & h2) | (h1 & h2);
`else
    assign rx_vote = rx_s;
`endif

endmodule

// File: rtl/serialrx.sv
// UART-style receiver: start bit, 8 data bits MSB first, stop bit; valid/ack byte delivery.
// Optional SERIALRX_MAJORITY_EN: 2-of-3 vote around each sample point, decision one cycle later.
module serialrx
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ack,
    output logic       overrun,
    output logic       frame_err,
    output logic       busy,
    output logic [1:0] state_dbg
);

    localparam int CW       = $clog2(CLKS_PER_BIT);
    localparam int IW       = $clog2(FRAME_BITS);
    localparam int HALF_BIT = CLKS_PER_BIT / 2;

    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_BITS - 1);
`ifdef SERIALRX_MAJORITY_EN
    localparam logic [CW-1:0] START_PT = CW'(HALF_BIT);
`else
    localparam logic [CW-1:0] START_PT = CW'(HALF_BIT - 1);
`endif

    // Valid/ack: valid stays high until an edge with ack=1; ack while valid=0 is ignored.
    // A good stop bit arriving while valid=1 and ack=0 overwrites data and sets overrun.

    logic rx_s, rx_vote;

    serialrx_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx      (rx),
        .rx_s    (rx_s),
        .rx_vote (rx_vote)
    );

    rx_state_t       state, state_n;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   idx;
    logic [7:0]      sh;
    logic            go_data, shift_en, stop_ok, stop_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n  = state;
        go_data  = 1'b0;
        shift_en = 1'b0;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) state_n = START;
            end
            START: begin
                if (cnt == START_PT) begin
                    if (rx_vote) begin
                        state_n = IDLE;
                    end else begin
                        state_n = DATA;
                        go_data = 1'b1;
                    end
                end
            end
            DATA: begin
                if (cnt == LAST_CNT) begin
                    shift_en = 1'b1;
                    if (idx == LAST_IDX) state_n = STOP;
                end
            end
            STOP: begin
                // Leave at mid stop bit so a start edge half a bit later is still caught.
                if (cnt == LAST_CNT) begin
                    state_n  = IDLE;
                    stop_ok  = rx_vote;
                    stop_bad = !rx_vote;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
            sh  <= '0;
        end else begin
            if (state == IDLE || go_data || cnt == LAST_CNT) cnt <= '0;
            else                                             cnt <= cnt + CW'(1);
            if (go_data)       idx <= '0;
            else if (shift_en) idx <= idx + IW'(1);
            if (shift_en) sh <= {sh[6:0], rx_vote};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data      <= 8'h00;
            valid     <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            if (stop_ok) begin
                data    <= sh;
                valid   <= 1'b1;
                overrun <= valid && !ack;
            end else if (ack && valid) begin
                valid   <= 1'b0;
                overrun <= 1'b0;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_serialrx.sv
// Self-checking bench for serialrx: line waveforms built per cycle, byte-level reference model.
`timescale 1ns/1ps
module tb_serialrx;

  localparam int CLKS      = 167;
  localparam int HALF      = CLKS / 2;
  localparam int FRAME_LEN = 10 * CLKS;
  localparam int WMAX      = 4000;
`ifdef SERIALRX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  // Drive cycle whose ack lands on the same edge as the stop-bit decision.
  localparam int STOP_ACK_CYC = HALF + 9 * CLKS + 2 + MAJ;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       ack = 1'b0;
  logic [7:0] data;
  logic       valid, overrun, frame_err, busy;
  logic [1:0] state_dbg;

  serialrx #(.CLKS_PER_BIT(CLKS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ack       (ack),
    .overrun   (overrun),
    .frame_err (frame_err),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / monitor ----------------
  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  int   fe_pulses = 0;
  int   fe_long = 0;
  int   busy_cycles = 0;
  logic fe_prev = 1'b0;

  always @(negedge clk) begin
    if (frame_err) begin
      if (fe_prev) fe_long++;
      else         fe_pulses++;
    end
    fe_prev = frame_err;
    if (busy) busy_cycles++;
  end

  // ---------------- reference model ----------------
  logic       wave[WMAX];
  int         wave_len;
  logic [7:0] exp_data = 8'h00;
  logic       exp_valid = 1'b0;
  logic       exp_ovr = 1'b0;
  logic [7:0] exp_byte;
  logic [7:0] exp_q[$];

  // Line value the receiver should decide on for frame bit k (0 start, 1..8 data, 9 stop).
  function automatic logic line_at(input int k);
    int c;
    c = HALF + k * CLKS;
`ifdef SERIALRX_MAJORITY_EN
    return (wave[c-1] & wave[c]) | (wave[c-1] & wave[c+1]) | (wave[c] & wave[c+1]);
`else
    return wave[c];
`endif
  endfunction

  task automatic model_reset();
    exp_data = 8'h00; exp_valid = 1'b0; exp_ovr = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_frame(input logic ack_same, output logic ok);
    logic [7:0] b;
    b = 8'h00;
    for (int k = 1; k <= 8; k++) b = {b[6:0], line_at(k)};
    exp_byte = b;
    ok = line_at(9);
    if (ok) begin
      if (exp_valid) void'(exp_q.pop_front());
      exp_ovr = exp_valid && !ack_same;
      exp_q.push_back(b);
      exp_data  = b;
      exp_valid = 1'b1;
    end
  endtask

  task automatic model_ack();
    if (exp_valid) begin
      exp_valid = 1'b0;
      exp_ovr   = 1'b0;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic build_frame(input logic [7:0] b, input logic stop, input logic g_data,
                             input logic g_stop, input int gap);
    int k;
    for (int i = 0; i < FRAME_LEN; i++) begin
      k = i / CLKS;
      if (k == 0)      wave[i] = 1'b0;
      else if (k == 9) wave[i] = stop;
      else             wave[i] = b[8-k];
    end
    if (g_data) for (int j = 1; j <= 8; j++) wave[HALF + j*CLKS] = ~wave[HALF + j*CLKS];
    if (g_stop) wave[HALF + 9*CLKS] = ~wave[HALF + 9*CLKS];
    for (int i = FRAME_LEN; i < FRAME_LEN + gap; i++) wave[i] = 1'b1;
    wave_len = FRAME_LEN + gap;
  endtask

  task automatic play(input int ack_at);
    for (int i = 0; i < wave_len; i++) begin
      @(posedge clk); #1;
      rx  = wave[i];
      ack = (i == ack_at);
    end
    ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      rx = 1'b1; ack = 1'b0;
    end
  endtask

  task automatic pulse_ack();
    @(posedge clk); #1; rx = 1'b1; ack = 1'b1;
    @(posedge clk); #1; ack = 1'b0;
    model_ack();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; rx = 1'b1; ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (data !== 8'h00)   begin failures++; $display("FAIL reset_data got=%h exp=00", data); end
    checks++; if (valid !== 1'b0)   begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst_n = 1'b1;
    model_reset();
    idle(5);
  endtask

  task automatic test_frame_error();
    int fe0, lg0; logic ok;
    fe0 = fe_pulses; lg0 = fe_long;
    build_frame(8'h3C, 1'b0, 1'b0, 1'b0, 200);
    model_frame(1'b0, ok);
    play(-1);
    checks++; if (fe_pulses - fe0 !== (ok ? 0 : 1)) begin failures++; $display("FAIL fe_pulse_count got=%0d exp=%0d", fe_pulses - fe0, ok ? 0 : 1); end
    checks++; if (fe_long - lg0 !== 0) begin failures++; $display("FAIL fe_width extra_cycles=%0d exp=0", fe_long - lg0); end
    checks++; if (valid !== exp_valid) begin failures++; $display("FAIL fe_valid got=%b exp=%b", valid, exp_valid); end
    checks++; if (data !== 8'h00)      begin failures++; $display("FAIL fe_data got=%h exp=00", data); end
  endtask

  task automatic test_start_glitch();
    int b0, fe0;
    b0 = busy_cycles; fe0 = fe_pulses;
    for (int i = 0; i < 300; i++) wave[i] = (i >= 40);
    wave_len = 300;
    play(-1);
    checks++; if (!(busy_cycles - b0 > 0 && busy_cycles - b0 < 100)) begin failures++; $display("FAIL glitch_busy_pulse cycles=%0d exp=1..99", busy_cycles - b0); end
    checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL glitch_busy_end got=%b exp=0", busy); end
    checks++; if (valid !== exp_valid) begin failures++; $display("FAIL glitch_valid got=%b exp=%b", valid, exp_valid); end
    checks++; if (data !== exp_data) begin failures++; $display("FAIL glitch_data got=%h exp=%h", data, exp_data); end
    checks++; if (fe_pulses !== fe0) begin failures++; $display("FAIL glitch_frame_err pulses=%0d exp=%0d", fe_pulses, fe0); end
  endtask

  task automatic test_single_frame();
    int fe0, rise_at; logic ok; logic [7:0] got, exp;
    fe0 = fe_pulses; rise_at = -1;
    build_frame(8'hA5, 1'b1, 1'b0, 1'b0, 30);
    model_frame(1'b0, ok);
    for (int i = 0; i < wave_len; i++) begin
      @(posedge clk); #1;
      rx = wave[i];
      if (valid && rise_at < 0) rise_at = i;
    end
    // First edge to see the low start bit is the one after drive cycle 0.
    checks++; if (rise_at !== 1 + HALF + 9*CLKS + 2 + MAJ) begin failures++; $display("FAIL a5_latency got=%0d exp=%0d", rise_at, 1 + HALF + 9*CLKS + 2 + MAJ); end
    checks++; if (data !== 8'hA5 || valid !== 1'b1) begin failures++; $display("FAIL a5_data got=%h/%b exp=a5/1", data, valid); end
    got = data; exp = exp_q.pop_front();
    checks++; if (got !== exp) begin failures++; $display("FAIL a5_scoreboard got=%h exp=%h", got, exp); end
    exp_q.push_front(exp);
    pulse_ack();
    void'(exp_q.pop_front());
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL a5_ack_valid got=%b exp=0", valid); end
    checks++; if (fe_pulses !== fe0) begin failures++; $display("FAIL a5_frame_err pulses=%0d exp=%0d", fe_pulses, fe0); end
  endtask

  task automatic test_overrun_back_to_back();
    logic ok; logic [7:0] got, exp;
    build_frame(8'h11, 1'b1, 1'b0, 1'b0, 0);
    model_frame(1'b0, ok);
    play(-1);
    build_frame(8'h22, 1'b1, 1'b0, 1'b0, 20);
    model_frame(1'b0, ok);
    play(-1);
    checks++; if (valid !== 1'b1 || data !== 8'h22 || overrun !== 1'b1) begin failures++; $display("FAIL ovr_state got=%b/%h/%b exp=1/22/1", valid, data, overrun); end
    checks++; if (exp_q.size() !== 1) begin failures++; $display("FAIL ovr_queue_depth got=%0d exp=1", exp_q.size()); end
    got = data; exp = exp_q.pop_front();
    checks++; if (got !== exp) begin failures++; $display("FAIL ovr_scoreboard got=%h exp=%h", got, exp); end
    pulse_ack();
    checks++; if (valid !== 1'b0 || overrun !== 1'b0) begin failures++; $display("FAIL ovr_ack got=%b/%b exp=0/0", valid, overrun); end
  endtask

  task automatic test_ack_same_edge();
    int fe0; logic ok;
    build_frame(8'h33, 1'b1, 1'b0, 1'b0, 10);
    model_frame(1'b0, ok);
    play(-1);
    build_frame(8'h44, 1'b1, 1'b0, 1'b0, 10);
    model_frame(1'b1, ok);
    play(STOP_ACK_CYC);
    checks++; if (valid !== 1'b1 || data !== 8'h44 || overrun !== 1'b0) begin failures++; $display("FAIL same_edge got=%b/%h/%b exp=1/44/0", valid, data, overrun); end
    fe0 = fe_pulses;
    build_frame(8'h55, 1'b0, 1'b0, 1'b0, 200);
    model_frame(1'b0, ok);
    play(-1);
    checks++; if (valid !== exp_valid || data !== exp_data || overrun !== exp_ovr) begin failures++; $display("FAIL fe_hold got=%b/%h/%b exp=%b/%h/%b", valid, data, overrun, exp_valid, exp_data, exp_ovr); end
    checks++; if (fe_pulses - fe0 !== 1) begin failures++; $display("FAIL fe_hold_pulses got=%0d exp=1", fe_pulses - fe0); end
  endtask

  task automatic test_break();
    int fe0;
    fe0 = fe_pulses;
    for (int i = 0; i < 3500; i++) wave[i] = (i >= 3200);
    wave_len = 3500;
    play(-1);
    // Two full frame times fit in the low period; the third attempt sees high at its start check.
    checks++; if (fe_pulses - fe0 !== 2) begin failures++; $display("FAIL break_pulses got=%0d exp=2", fe_pulses - fe0); end
    checks++; if (valid !== exp_valid || data !== exp_data) begin failures++; $display("FAIL break_hold got=%b/%h exp=%b/%h", valid, data, exp_valid, exp_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL break_idle got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid_frame();
    logic ok;
    build_frame(8'hFF, 1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 5*CLKS + 60; i++) begin
      @(posedge clk); #1;
      rx = wave[i];
    end
    rst_n = 1'b0;
    #2;
    checks++; if (data !== 8'h00 || valid !== 1'b0 || overrun !== 1'b0) begin failures++; $display("FAIL midrst_out got=%h/%b/%b exp=00/0/0", data, valid, overrun); end
    checks++; if (busy !== 1'b0 || frame_err !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b/%b exp=0/0", busy, frame_err); end
    model_reset();
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1; rx = 1'b1;
    idle(1200);
    build_frame(8'h5A, 1'b1, 1'b0, 1'b0, 20);
    model_frame(1'b0, ok);
    play(-1);
    checks++; if (data !== 8'h5A || valid !== 1'b1 || overrun !== 1'b0) begin failures++; $display("FAIL midrst_5a got=%h/%b/%b exp=5a/1/0", data, valid, overrun); end
    pulse_ack();
    void'(exp_q.pop_front());
  endtask

  task automatic test_majority_glitch();
    int fe0; logic ok; logic [7:0] req;
`ifdef SERIALRX_MAJORITY_EN
    req = 8'h81;
`else
    req = 8'h7E;
`endif
    build_frame(8'h81, 1'b1, 1'b1, 1'b0, 200);
    model_frame(1'b0, ok);
    play(-1);
    checks++; if (data !== req || valid !== 1'b1) begin failures++; $display("FAIL glitch_data_bits got=%h/%b exp=%h/1", data, valid, req); end
    checks++; if (data !== exp_byte) begin failures++; $display("FAIL glitch_model got=%h exp=%h", data, exp_byte); end
    pulse_ack();
    void'(exp_q.pop_front());
    fe0 = fe_pulses;
    build_frame(8'h81, 1'b1, 1'b1, 1'b1, 200);
    model_frame(1'b0, ok);
    play(-1);
    checks++; if (valid !== exp_valid || data !== exp_data) begin failures++; $display("FAIL glitch_all got=%b/%h exp=%b/%h", valid, data, exp_valid, exp_data); end
    checks++; if (fe_pulses - fe0 !== (ok ? 0 : 1)) begin failures++; $display("FAIL glitch_all_fe got=%0d exp=%0d", fe_pulses - fe0, ok ? 0 : 1); end
    if (exp_valid) begin
      pulse_ack();
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_random();
    int fe0, gap; logic ok, bad; logic [7:0] b, got, exp;
    for (int n = 0; n < 12; n++) begin
      if (exp_valid && $urandom_range(0, 2) != 0) begin
        got = data; exp = exp_q.pop_front();
        checks++; if (got !== exp) begin failures++; $display("FAIL rnd_scoreboard n=%0d got=%h exp=%h", n, got, exp); end
        pulse_ack();
      end
      b   = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 5) == 0);
      gap = bad ? 200 : $urandom_range(0, 40);
      fe0 = fe_pulses;
      build_frame(b, !bad, 1'b0, 1'b0, gap);
      model_frame(1'b0, ok);
      play(-1);
      checks++; if (data !== exp_data || valid !== exp_valid || overrun !== exp_ovr) begin failures++; $display("FAIL rnd_frame n=%0d got=%h/%b/%b exp=%h/%b/%b", n, data, valid, overrun, exp_data, exp_valid, exp_ovr); end
      checks++; if (fe_pulses - fe0 !== (ok ? 0 : 1)) begin failures++; $display("FAIL rnd_fe n=%0d got=%0d exp=%0d", n, fe_pulses - fe0, ok ? 0 : 1); end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_frame_error();
    test_start_glitch();
    test_single_frame();
    test_overrun_back_to_back();
    test_ack_same_edge();
    test_break();
    test_reset_mid_frame();
    test_majority_glitch();
    test_random();
    checks++; if (fe_long !== 0) begin failures++; $display("FAIL fe_single_cycle extra_cycles=%0d exp=0", fe_long); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
